// File: rtl/evict_ctrl_pkg.sv
// Shared definitions for the o-RAM miss-side eviction controller:
// default geometry, LRU entry field offsets and FSM state codes.
package evict_ctrl_pkg;

    localparam int DEF_SET_CNT   = 4;
    localparam int DEF_BLOCK_CNT = 6;
    localparam int DEF_LINE_W    = 512;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_LRU  = 4'd1;
    localparam logic [3:0] ST_CAPT = 4'd2;
    localparam logic [3:0] ST_VRD  = 4'd3;
    localparam logic [3:0] ST_VLAT = 4'd4;
    localparam logic [3:0] ST_WB   = 4'd5;
    localparam logic [3:0] ST_RREQ = 4'd6;
    localparam logic [3:0] ST_RRSP = 4'd7;
    localparam logic [3:0] ST_FILL = 4'd8;

    // LRU entry layout is {V, D, way[setCnt], tag[setCnt]}.
    function automatic int lruValidBit(input int setCnt);
        return 2 * setCnt + 1;
    endfunction

    function automatic int lruDirtyBit(input int setCnt);
        return 2 * setCnt;
    endfunction

endpackage

// File: rtl/evict_ctrl.sv
// Miss-side controller: asks the LRU for a victim, writes it back to DRAM
// when valid and dirty, fetches the missing line and installs it in the victim way.
module evict_ctrl
    import evict_ctrl_pkg::*;
#(
    parameter int SET_CNT   = DEF_SET_CNT,
    parameter int BLOCK_CNT = DEF_BLOCK_CNT,
    parameter int LINE_W    = DEF_LINE_W
) (
    input  logic                         clk,
    input  logic                         RST_n,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    input  logic [SET_CNT+BLOCK_CNT-1:0] miss_addr,
    output logic                         mem_en,
    output logic [SET_CNT+BLOCK_CNT-1:0] set_index_mem,
    input  logic [2*SET_CNT+1:0]         victim_lru,
    output logic                         dat_rd_en,
    output logic [SET_CNT+BLOCK_CNT-1:0] dat_rd_addr,
    input  logic [LINE_W-1:0]            dat_rd_data,
    output logic                         mem_wr_valid,
    input  logic                         mem_wr_ready,
    output logic [SET_CNT+BLOCK_CNT-1:0] mem_wr_addr,
    output logic [LINE_W-1:0]            mem_wr_data,
    output logic                         mem_rd_valid,
    input  logic                         mem_rd_ready,
    output logic [SET_CNT+BLOCK_CNT-1:0] mem_rd_addr,
    input  logic                         mem_rsp_valid,
    input  logic [LINE_W-1:0]            mem_rsp_data,
    output logic                         dat_wr_en,
    output logic [SET_CNT+BLOCK_CNT-1:0] dat_wr_addr,
    output logic [LINE_W-1:0]            dat_wr_data,
    output logic                         fill_done,
    output logic [SET_CNT-1:0]           fill_way
);

    localparam int AW = SET_CNT + BLOCK_CNT;
    localparam int VB = lruValidBit(SET_CNT);
    localparam int DB = lruDirtyBit(SET_CNT);

    logic [3:0]         state_q, state_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic               v_q, v_d;
    logic               d_q, d_d;
    logic [SET_CNT-1:0] way_q, way_d;
    logic [SET_CNT-1:0] vtag_q, vtag_d;
    logic [LINE_W-1:0]  buf_q, buf_d;

    logic [BLOCK_CNT-1:0] index;
    logic                 needWb;

    assign index  = addr_q[BLOCK_CNT-1:0];
    assign needWb = v_q && d_q;

    // The line buffer holds the victim data during writeback and is then
    // reused for the refill data, so only one line register exists.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        v_d     = v_q;
        d_d     = d_q;
        way_d   = way_q;
        vtag_d  = vtag_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    addr_d  = miss_addr;
                    state_d = ST_LRU;
                end
            end
            ST_LRU:  state_d = ST_CAPT;
            ST_CAPT: begin
                v_d     = victim_lru[VB];
                d_d     = victim_lru[DB];
                way_d   = victim_lru[2*SET_CNT-1:SET_CNT];
                vtag_d  = victim_lru[SET_CNT-1:0];
                state_d = (victim_lru[VB] && victim_lru[DB]) ? ST_VRD : ST_RREQ;
            end
            ST_VRD:  state_d = ST_VLAT;
            ST_VLAT: begin
                buf_d   = dat_rd_data;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (mem_wr_ready) state_d = ST_RREQ;
            end
            ST_RREQ: begin
                if (mem_rd_ready) state_d = ST_RRSP;
            end
            ST_RRSP: begin
                if (mem_rsp_valid) begin
                    buf_d   = mem_rsp_data;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            v_q     <= 1'b0;
            d_q     <= 1'b0;
            way_q   <= '0;
            vtag_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            v_q     <= v_d;
            d_q     <= d_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
            buf_q   <= buf_d;
        end
    end

    // miss_ready is gated by reset so every output reads 0 while RST_n is low.
    assign miss_ready    = RST_n && (state_q == ST_IDLE);
    assign mem_en        = (state_q == ST_LRU);
    assign set_index_mem = addr_q;
    assign dat_rd_en     = (state_q == ST_VRD) && needWb;
    assign dat_rd_addr   = {way_q, index};
    assign mem_wr_valid  = (state_q == ST_WB) && needWb;
    assign mem_wr_addr   = {vtag_q, index};
    assign mem_wr_data   = buf_q;
    assign mem_rd_valid  = (state_q == ST_RREQ);
    assign mem_rd_addr   = addr_q;
    assign dat_wr_en     = (state_q == ST_FILL);
    assign dat_wr_addr   = {way_q, index};
    assign dat_wr_data   = buf_q;
    assign fill_done     = (state_q == ST_FILL);
    assign fill_way      = way_q;

endmodule

// File: tb/tb_evict_ctrl.sv
// Scoreboard bench for evict_ctrl: LRU, data RAM and DRAM are modelled here,
// expected transfers are queued at stimulus time and popped when the DUT emits them.
module tb_evict_ctrl;

    localparam int SC = 4;
    localparam int BC = 6;
    localparam int AW = SC + BC;
    localparam int LW = 512;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic [SC-1:0] way;
    } exp_t;

    logic            clk = 1'b0;
    logic            RST_n = 1'b0;
    logic            miss_valid = 1'b0;
    logic            miss_ready;
    logic [AW-1:0]   miss_addr = '0;
    logic            mem_en;
    logic [AW-1:0]   set_index_mem;
    logic [2*SC+1:0] victim_lru = '0;
    logic            dat_rd_en;
    logic [AW-1:0]   dat_rd_addr;
    logic [LW-1:0]   dat_rd_data = '0;
    logic            mem_wr_valid;
    logic            mem_wr_ready;
    logic [AW-1:0]   mem_wr_addr;
    logic [LW-1:0]   mem_wr_data;
    logic            mem_rd_valid;
    logic            mem_rd_ready = 1'b1;
    logic [AW-1:0]   mem_rd_addr;
    logic            mem_rsp_valid;
    logic [LW-1:0]   mem_rsp_data;
    logic            dat_wr_en;
    logic [AW-1:0]   dat_wr_addr;
    logic [LW-1:0]   dat_wr_data;
    logic            fill_done;
    logic [SC-1:0]   fill_way;

    evict_ctrl #(.SET_CNT(SC), .BLOCK_CNT(BC), .LINE_W(LW)) dut (
        .clk(clk), .RST_n(RST_n),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .mem_en(mem_en), .set_index_mem(set_index_mem), .victim_lru(victim_lru),
        .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dat_wr_en(dat_wr_en), .dat_wr_addr(dat_wr_addr), .dat_wr_data(dat_wr_data),
        .fill_done(fill_done), .fill_way(fill_way)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    exp_t          wbQ[$];
    exp_t          fillQ[$];
    logic [AW-1:0] rdQ[$];

    logic [2*SC+1:0] curVictim = '0;
    logic [LW-1:0]   curLine = '0;
    logic [LW-1:0]   curRsp = '0;
    logic [AW-1:0]   curAddr = '0;
    logic [AW-1:0]   expRdAddr = '0;
    int              wrStall = 0;
    int              wrWaitCnt = 0;
    logic            rspPending = 1'b0;

    int memEnCount = 0;
    int datRdCount = 0;
    int wrValidCycles = 0;

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                               input logic [LW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // LRU model: registers the victim one cycle after the memEN pulse.
    always @(posedge clk) victim_lru <= mem_en ? curVictim : '0;

    always @(posedge clk) dat_rd_data <= dat_rd_en ? curLine : '0;

    always @(posedge clk) wrWaitCnt <= mem_wr_valid ? wrWaitCnt + 1 : 0;
    assign mem_wr_ready = (wrWaitCnt >= wrStall);

    // Zero-wait DRAM: the response appears in the cycle after the read handshake.
    always @(posedge clk or negedge RST_n) begin
        if (!RST_n) rspPending <= 1'b0;
        else        rspPending <= mem_rd_valid && mem_rd_ready;
    end
    assign mem_rsp_valid = rspPending;
    assign mem_rsp_data  = curRsp;

    always @(negedge clk) begin
        if (RST_n) begin
            if (mem_en) begin
                memEnCount++;
                checkOutput("set_index_mem", set_index_mem, curAddr);
            end
            if (dat_rd_en) begin
                datRdCount++;
                checkOutput("dat_rd_addr", dat_rd_addr, expRdAddr);
            end
            if (mem_wr_valid) begin
                wrValidCycles++;
                if (wbQ.size() == 0) checkOutput("mem_wr_valid unexpected", mem_wr_valid, 1'b0);
                else begin
                    checkOutput("mem_wr_addr", mem_wr_addr, wbQ[0].addr);
                    checkOutput("mem_wr_data", mem_wr_data, wbQ[0].data);
                    if (mem_wr_ready) void'(wbQ.pop_front());
                end
            end
            if (mem_rd_valid) begin
                if (rdQ.size() == 0) checkOutput("mem_rd_valid unexpected", mem_rd_valid, 1'b0);
                else begin
                    checkOutput("mem_rd_addr", mem_rd_addr, rdQ[0]);
                    checkOutput("writeback before read", wbQ.size(), 0);
                    if (mem_rd_ready) void'(rdQ.pop_front());
                end
            end
            if (dat_wr_en) begin
                if (fillQ.size() == 0) checkOutput("dat_wr_en unexpected", dat_wr_en, 1'b0);
                else begin
                    checkOutput("dat_wr_addr", dat_wr_addr, fillQ[0].addr);
                    checkOutput("dat_wr_data", dat_wr_data, fillQ[0].data);
                    checkOutput("fill_way", fill_way, fillQ[0].way);
                    checkOutput("fill_done", fill_done, 1'b1);
                    void'(fillQ.pop_front());
                end
            end else if (fill_done) begin
                checkOutput("fill_done without dat_wr_en", fill_done, 1'b0);
            end
        end
    end

    task automatic pushExpect(input logic [AW-1:0] addr, input logic [2*SC+1:0] victim);
        exp_t e;
        if (victim[2*SC+1] && victim[2*SC]) begin
            e.addr = {victim[SC-1:0], addr[BC-1:0]};
            e.data = curLine;
            e.way  = victim[2*SC-1:SC];
            wbQ.push_back(e);
        end
        rdQ.push_back(addr);
        e.addr = {victim[2*SC-1:SC], addr[BC-1:0]};
        e.data = curRsp;
        e.way  = victim[2*SC-1:SC];
        fillQ.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic [AW-1:0] addr,
                                 input logic [2*SC+1:0] victim, input logic [LW-1:0] line,
                                 input logic [LW-1:0] rsp, input int stall);
        int lat;
        int expLat;
        int enBefore;
        int rdBefore;
        int wrBefore;
        bit done;
        bit dirty;
        dirty     = victim[2*SC+1] && victim[2*SC];
        curAddr   = addr;
        curVictim = victim;
        curLine   = line;
        curRsp    = rsp;
        wrStall   = stall;
        expRdAddr = {victim[2*SC-1:SC], addr[BC-1:0]};
        pushExpect(addr, victim);
        enBefore = memEnCount;
        rdBefore = datRdCount;
        wrBefore = wrValidCycles;
        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = addr;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            miss_valid = 1'b0;
            lat++;
            if (fill_done) done = 1'b1;
        end
        expLat = dirty ? 8 + stall : 5;
        if (!done) checkOutput({tag, " fill timeout"}, fill_done, 1'b1);
        else       checkOutput({tag, " fill latency"}, lat, expLat);
        @(negedge clk);
        checkOutput({tag, " miss_ready after fill"}, miss_ready, 1'b1);
        checkOutput({tag, " mem_en pulses"}, memEnCount - enBefore, 1);
        checkOutput({tag, " dat_rd_en cycles"}, datRdCount - rdBefore, dirty ? 1 : 0);
        checkOutput({tag, " mem_wr_valid cycles"}, wrValidCycles - wrBefore,
                    dirty ? stall + 1 : 0);
    endtask

    initial begin
        int enBefore;
        int wrBefore;
        int k;
        int enIdx[$];
        int fillIdx[$];
        bit seen;

        repeat (3) @(negedge clk);
        RST_n = 1'b1;
        @(negedge clk);
        checkOutput("reset miss_ready", miss_ready, 1'b1);
        checkOutput("reset mem_en", mem_en, 1'b0);
        checkOutput("reset mem_wr_valid", mem_wr_valid, 1'b0);
        checkOutput("reset mem_rd_valid", mem_rd_valid, 1'b0);
        checkOutput("reset dat_wr_en", dat_wr_en, 1'b0);
        checkOutput("reset dat_rd_en", dat_rd_en, 1'b0);
        checkOutput("reset fill_done", fill_done, 1'b0);
        checkOutput("reset set_index_mem", set_index_mem, '0);
        checkOutput("reset mem_wr_data", mem_wr_data, '0);

        applyStimulus("invalid victim", {4'd5, 6'd3}, {1'b0, 1'b0, 4'd2, 4'd0},
                      {16{32'h1234_5678}}, {64{8'hA5}}, 0);
        applyStimulus("clean victim", {4'd6, 6'd10}, {1'b1, 1'b0, 4'd1, 4'd7},
                      {16{32'h0BAD_F00D}}, {16{32'hC0FF_EE01}}, 0);
        applyStimulus("dirty victim", {4'd8, 6'd4}, {1'b1, 1'b1, 4'd3, 4'd9},
                      {32{16'hDEAD}}, {16{32'h5A5A_0F0F}}, 0);
        applyStimulus("dirty stall5", {4'd2, 6'd33}, {1'b1, 1'b1, 4'd11, 4'd14},
                      {16{$urandom}}, {16{$urandom}}, 5);

        // Reset in the middle of a stalled writeback.
        curAddr   = {4'd1, 6'd7};
        curVictim = {1'b1, 1'b1, 4'd4, 4'd12};
        curLine   = {16{32'hFACE_CAFE}};
        curRsp    = {16{32'h0000_1111}};
        wrStall   = 50;
        expRdAddr = {4'd4, 6'd7};
        pushExpect(curAddr, curVictim);
        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = curAddr;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            miss_valid = 1'b0;
            if (mem_wr_valid) seen = 1'b1;
        end
        checkOutput("reach WB before reset", mem_wr_valid, 1'b1);
        repeat (2) @(negedge clk);
        #2 RST_n = 1'b0;
        #1;
        checkOutput("async reset mem_wr_valid", mem_wr_valid, 1'b0);
        checkOutput("async reset miss_ready", miss_ready, 1'b0);
        checkOutput("async reset mem_wr_addr", mem_wr_addr, '0);
        checkOutput("async reset mem_wr_data", mem_wr_data, '0);
        wbQ.delete();
        rdQ.delete();
        fillQ.delete();
        @(negedge clk);
        RST_n   = 1'b1;
        wrStall = 0;
        #1;
        checkOutput("post reset miss_ready", miss_ready, 1'b1);
        enBefore = memEnCount;
        wrBefore = wrValidCycles;
        repeat (10) @(negedge clk);
        checkOutput("post reset no mem_wr_valid", wrValidCycles - wrBefore, 0);
        checkOutput("post reset no mem_en", memEnCount - enBefore, 0);

        // Back-to-back misses with miss_valid held high.
        curAddr   = {4'd9, 6'd21};
        curVictim = {1'b1, 1'b0, 4'd6, 4'd3};
        curLine   = '0;
        curRsp    = {16{32'h7777_AAAA}};
        expRdAddr = {4'd6, 6'd21};
        pushExpect(curAddr, curVictim);
        pushExpect(curAddr, curVictim);
        enBefore = memEnCount;
        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = curAddr;
        k = 0;
        for (int i = 0; i < 100 && fillIdx.size() < 2; i++) begin
            @(negedge clk);
            k++;
            if (mem_en) enIdx.push_back(k);
            if (fill_done) fillIdx.push_back(k);
        end
        miss_valid = 1'b0;
        checkOutput("b2b fills", fillIdx.size(), 2);
        checkOutput("b2b mem_en pulses", enIdx.size(), 2);
        if (enIdx.size() == 2 && fillIdx.size() >= 1)
            checkOutput("b2b second accept after fill", enIdx[1], fillIdx[0] + 2);
        repeat (5) @(negedge clk);
        checkOutput("b2b total mem_en", memEnCount - enBefore, 2);
        checkOutput("b2b idle miss_ready", miss_ready, 1'b1);
        checkOutput("scoreboard fills drained", fillQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/evict_ctrl.md
# evict_ctrl

Miss-side controller for the o-RAM cache: it is the consumer of the LRU tracker's victim output. On a PE miss it pulses the LRU `memEN`, captures the returned victim entry `{Valid, Dirty, Way, Tag}`, writes the victim line back to DRAM when it is valid and dirty, fetches the missing line, and writes that line into the victim way of the data array. It sits between the hit/miss detect stage, the LRU, the cache data RAM and the DRAM port.

## Interface
- `SET_CNT`, 4: tag (set) field width; equals the way-id field width in the LRU entry.
- `BLOCK_CNT`, 6: index width; cache depth is 2^BLOCK_CNT.
- `LINE_W`, 512: cache line width in bits.

- `clk` in 1: clock; all state changes on the rising edge.
- `RST_n` in 1: asynchronous, active-low reset.
- `miss_valid` in 1: miss request.
- `miss_ready` out 1: high only in IDLE.
- `miss_addr` in SET_CNT+BLOCK_CNT: `{tag, index}` of the missing line.
- `mem_en` out 1: one-cycle pulse to the LRU `memEN`.
- `set_index_mem` out SET_CNT+BLOCK_CNT: latched `miss_addr`, driven with `mem_en`.
- `victim_lru` in SET_CNT*2+2: LRU `Least_used_lru` output, `{V, D, way[SET_CNT], tag[SET_CNT]}`.
- `dat_rd_en` out 1; `dat_rd_addr` out SET_CNT+BLOCK_CNT `{way, index}`; `dat_rd_data` in LINE_W, 1-cycle read latency.
- `mem_wr_valid` out 1; `mem_wr_ready` in 1; `mem_wr_addr` out SET_CNT+BLOCK_CNT `{victim tag, index}`; `mem_wr_data` out LINE_W.
- `mem_rd_valid` out 1; `mem_rd_ready` in 1; `mem_rd_addr` out SET_CNT+BLOCK_CNT.
- `mem_rsp_valid` in 1; `mem_rsp_data` in LINE_W.
- `dat_wr_en` out 1; `dat_wr_addr` out SET_CNT+BLOCK_CNT `{way, index}`; `dat_wr_data` out LINE_W.
- `fill_done` out 1: one-cycle pulse when the line is installed; `fill_way` out SET_CNT.

## Operation
- States: IDLE, LRU, CAPT, VRD, VLAT, WB, RREQ, RRSP, FILL.
- IDLE: on `miss_valid && miss_ready`, latch `miss_addr` and go to LRU.
- LRU: `mem_en`=1 for exactly one cycle, `set_index_mem` = latched address. Next state is CAPT.
- CAPT: register `victim_lru` into `{v, d, way, vtag}`. If `v && d`, go to VRD; otherwise go to RREQ. A clean or invalid victim is never written back.
- VRD: `dat_rd_en`=1 with `dat_rd_addr`={way, index}. Next state is VLAT.
- VLAT: register `dat_rd_data` into the writeback buffer. Next state is WB.
- WB: hold `mem_wr_valid` with stable address and data until `mem_wr_ready`. The transfer happens in the cycle where both are high; then go to RREQ.
- RREQ: hold `mem_rd_valid` with `mem_rd_addr`=latched miss address until `mem_rd_ready`; then go to RRSP.
- RRSP: wait for `mem_rsp_valid` and register `mem_rsp_data`. There is no timeout. Then go to FILL.
- FILL: `dat_wr_en`=1 with `{way, index}` and the fill data, plus `fill_done`=1 and `fill_way`=way. Next state is IDLE.
- Only one miss is outstanding at a time. `miss_valid` is ignored outside IDLE.
- The LRU has already marked the new entry valid and clean at `mem_en`; dirty marking stays with the PE write path.

## Timing
- Reset, asynchronous: state=IDLE; all `*_valid`, `*_en` and `fill_done` outputs = 0; `miss_ready`=1 immediately after reset deasserts; all address, data and captured registers = 0. Reset mid-transaction aborts it with no further memory or data-array activity. Any DRAM handshake in flight is dropped.
- Miss accept at edge t: `mem_en` is high in cycle t+1. `victim_lru` is valid in t+2 (the LRU registers it) and is captured at the end of t+2.
- Clean path, zero-wait memory: `mem_rd_valid` in t+3; response at the earliest in t+4; FILL at t+5; IDLE/`miss_ready` at t+6.
- Dirty path adds VRD, VLAT and WB: minimum 3 extra cycles plus `mem_wr_ready` stall cycles.
- Valid/ready: outputs never drop before the handshake completes; address and data stay constant while valid.
- `mem_rsp_valid` outside RRSP is ignored.

## Structure
- Macros `SET_CNT`, `BLOCK_CNT`, `LINE_W` and the LRU entry field offsets (V = MSB, D = MSB-1, way, tag) go in the shared `Cache_parameter.vh`, used by both the LRU and this block.
- The state encoding is a local enum.
- No sub-module is needed. The line buffer is one LINE_W register, shared between writeback data and fill data.

## Test plan
- Invalid victim (`victim_lru`={0,0,way=2,tag=0}), miss addr {tag=5, idx=3}: no `mem_wr_valid`; `mem_rd_addr`={5,3}; response 0xA5…: `dat_wr_addr`={2,3}, `fill_way`=2.
- Valid clean victim {1,0,1,7}: no writeback and no `dat_rd_en`; the refill proceeds.
- Dirty victim {1,1,3,9}, idx=4, `dat_rd_data`=0xDEAD…: `mem_wr_addr`={9,4} with that data, before any `mem_rd_valid`.
- `mem_wr_ready` held low for 5 cycles: `mem_wr_valid`, address and data stay stable; transfer completes on cycle 6.
- `RST_n` low during WB: all outputs are 0 asynchronously; after release `miss_ready`=1 and no further `mem_wr_valid`.
- Back-to-back misses, with `miss_valid` held high: the second miss is accepted only after `fill_done`; exactly one `mem_en` pulse per miss.
